// File: rtl/led_event_arbiter.sv
// led_event_arbiter
// Shares one debug LED between several single-cycle event sources. Each
// event is latched as pending; a round-robin arbiter grants the LED to one
// pending source at a time and plays its blink code (source i blinks i+1
// times), followed by a dark gap.
//
// Build option: define LED_ARB_HEARTBEAT_EN to make the LED toggle every
// GAP_TICKS cycles while idle with nothing pending (alive indicator).
`timescale 1ns/1ps

module led_event_arbiter #(
    parameter int N_EVT       = 4,
    parameter int BLINK_TICKS = 25_000_000,
    parameter int GAP_TICKS   = 100_000_000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_EVT-1:0]                              evt,
    input  logic                                          clr,
    output logic                                          led,
    output logic                                          busy,
    output logic [((N_EVT > 1) ? $clog2(N_EVT) : 1)-1:0]  cur_id,
    output logic [N_EVT-1:0]                              pending
);

    localparam int ID_W  = (N_EVT > 1) ? $clog2(N_EVT) : 1;
    localparam int BL_W  = $clog2(N_EVT + 1);
    localparam int MAX_T = (BLINK_TICKS > GAP_TICKS) ? BLINK_TICKS : GAP_TICKS;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_led;
    logic               r_busy;
    logic [ID_W-1:0]    r_curId;
    logic [BL_W-1:0]    r_blinks;
    logic [N_EVT-1:0]   r_pending;

    state_t             w_stateNext;
    logic [CNT_W-1:0]   w_cntNext;
    logic               w_ledNext;
    logic               w_busyNext;
    logic [ID_W-1:0]    w_curIdNext;
    logic [BL_W-1:0]    w_blinksNext;
    logic [N_EVT-1:0]   w_pendingNext;
    logic [N_EVT-1:0]   w_grantMask;

    logic               w_anyPending;
    logic [N_EVT-1:0]   w_rot;
    logic [ID_W-1:0]    w_grantIdx;

`ifdef LED_ARB_HEARTBEAT_EN
    logic [CNT_W-1:0]   r_hbCnt;
    logic [CNT_W-1:0]   w_hbCntNext;
`endif

    // Round-robin pick: rotate pending so that index cur_id+1 lands at bit 0,
    // then take the lowest set bit and map it back to a source index.
    always_comb begin
        w_anyPending = |r_pending;
        w_rot        = N_EVT'({r_pending, r_pending} >> (int'(r_curId) + 1));
        w_grantIdx   = '0;
        for (int k = N_EVT - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_grantIdx = ID_W'((int'(r_curId) + 1 + k) % N_EVT);
            end
        end
    end

    // Next-state, blink sequencing, LED drive and pending-bit update.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_ledNext    = r_led;
        w_curIdNext  = r_curId;
        w_blinksNext = r_blinks;
        w_grantMask  = '0;
`ifdef LED_ARB_HEARTBEAT_EN
        w_hbCntNext  = r_hbCnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_anyPending) begin
                    w_grantMask  = N_EVT'(1) << w_grantIdx;
                    w_curIdNext  = w_grantIdx;
                    w_blinksNext = BL_W'(w_grantIdx) + BL_W'(1);
                    w_ledNext    = 1'b1;
                    w_cntNext    = '0;
                    w_stateNext  = S_ON;
                end else begin
`ifdef LED_ARB_HEARTBEAT_EN
                    if (r_hbCnt == GAP_LAST) begin
                        w_hbCntNext = '0;
                        w_ledNext   = ~r_led;
                    end else begin
                        w_hbCntNext = r_hbCnt + CNT_W'(1);
                    end
`else
                    w_ledNext = 1'b0;
`endif
                end
            end

            S_ON: begin
                if (r_cnt == BLINK_LAST) begin
                    w_cntNext    = '0;
                    w_ledNext    = 1'b0;
                    w_blinksNext = r_blinks - BL_W'(1);
                    w_stateNext  = S_OFF;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            S_OFF: begin
                if (r_cnt == BLINK_LAST) begin
                    w_cntNext = '0;
                    if (r_blinks == '0) begin
                        w_stateNext = S_GAP;
                    end else begin
                        w_ledNext   = 1'b1;
                        w_stateNext = S_ON;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            S_GAP: begin
                w_ledNext = 1'b0;
                if (r_cnt == GAP_LAST) begin
                    w_cntNext   = '0;
                    w_stateNext = S_IDLE;
`ifdef LED_ARB_HEARTBEAT_EN
                    w_hbCntNext = '0;
`endif
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_stateNext = S_IDLE;
                w_ledNext   = 1'b0;
                w_cntNext   = '0;
            end
        endcase

        w_busyNext    = (w_stateNext != S_IDLE);
        w_pendingNext = (r_pending & ~{N_EVT{clr}} & ~w_grantMask) | evt;
    end

    // State and datapath registers; reset darkens the LED immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_curId   <= '0;
            r_blinks  <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_led     <= w_ledNext;
            r_busy    <= w_busyNext;
            r_curId   <= w_curIdNext;
            r_blinks  <= w_blinksNext;
            r_pending <= w_pendingNext;
        end
    end

`ifdef LED_ARB_HEARTBEAT_EN
    // Heartbeat phase counter; only advances while idle with nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hbCnt <= '0;
        end else begin
            r_hbCnt <= w_hbCntNext;
        end
    end
`endif

    assign led     = r_led;
    assign busy    = r_busy;
    assign cur_id  = r_curId;
    assign pending = r_pending;

endmodule

// File: tb/tb_led_event_arbiter.sv
// Testbench for led_event_arbiter (N_EVT=4, BLINK_TICKS=4, GAP_TICKS=8).
// A queue-based reference model expands each granted code into its LED
// waveform and is compared against the DUT every cycle.
`timescale 1ns/1ps

module tb_led_event_arbiter;

    localparam int N = 4;
    localparam int B = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] evt;
    logic       clr;
    logic       led;
    logic       busy;
    logic [1:0] cur_id;
    logic [3:0] pending;

    int compared   = 0;
    int mismatched = 0;

    bit         mq[$];
    logic [3:0] mPend;
    int         mCur;

    led_event_arbiter #(
        .N_EVT      (N),
        .BLINK_TICKS(B),
        .GAP_TICKS  (G)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .evt    (evt),
        .clr    (clr),
        .led    (led),
        .busy   (busy),
        .cur_id (cur_id),
        .pending(pending)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic modelReset();
        mq.delete();
        mPend = 4'b0000;
        mCur  = 0;
    endtask

    task automatic modelEdge(input logic [3:0] e, input logic c);
        logic [3:0] gm;
        int         pick;
        bit         found;
        int         idx;
        gm    = 4'b0000;
        pick  = 0;
        found = 1'b0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
        end else if (mPend != 4'b0000) begin
            for (int k = 1; k <= N; k++) begin
                idx = (mCur + k) % N;
                if (!found && (((mPend >> idx) & 4'b0001) != 4'b0000)) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
            mCur = pick;
            gm   = 4'b0001 << pick;
            for (int b = 0; b <= pick; b++) begin
                repeat (B) mq.push_back(1'b1);
                repeat (B) mq.push_back(1'b0);
            end
            repeat (G) mq.push_back(1'b0);
        end
        mPend = (mPend & ~{4{c}} & ~gm) | e;
    endtask

    task automatic checkOutput(input string tag);
        logic       expLed;
        logic       expBusy;
        logic [1:0] expId;
        expLed  = (mq.size() != 0) ? mq[0] : 1'b0;
        expBusy = (mq.size() != 0);
        expId   = 2'(mCur);
        compared++;
        assert (led === expLed) else begin
            mismatched++;
            $error("[TB] FAIL %s led: observed %b expected %b at %0t", tag, led, expLed, $time);
        end
        compared++;
        assert (busy === expBusy) else begin
            mismatched++;
            $error("[TB] FAIL %s busy: observed %b expected %b at %0t", tag, busy, expBusy, $time);
        end
        compared++;
        assert (cur_id === expId) else begin
            mismatched++;
            $error("[TB] FAIL %s cur_id: observed %0d expected %0d at %0t", tag, cur_id, expId, $time);
        end
        compared++;
        assert (pending === mPend) else begin
            mismatched++;
            $error("[TB] FAIL %s pending: observed %b expected %b at %0t", tag, pending, mPend, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] e, input logic c, input string tag);
        evt = e;
        clr = c;
        @(posedge clk);
        modelEdge(e, c);
        @(negedge clk);
        evt = 4'b0000;
        clr = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idleSteps(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (mq.size() != 0 || mPend != 4'b0000); i++) begin
            applyStimulus(4'b0000, 1'b0, tag);
        end
        idleSteps(3, tag);
    endtask

    task automatic resetPulse(input string tag);
        rst = 1'b1;
        evt = 4'b0000;
        clr = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput(tag);
    endtask

    // Directed scenarios followed by a randomized soak, all model-checked.
    initial begin
        rst = 1'b1;
        evt = 4'b0000;
        clr = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset");

        $display("[TB] idle after reset");
        idleSteps(50, "idle");

        $display("[TB] single event on source 2");
        applyStimulus(4'b0100, 1'b0, "src2");
        drain("src2");

        $display("[TB] three simultaneous events");
        resetPulse("reset3");
        applyStimulus(4'b1011, 1'b0, "multi");
        drain("multi");

        $display("[TB] re-fire during own code");
        applyStimulus(4'b0010, 1'b0, "refire");
        applyStimulus(4'b0000, 1'b0, "refire");
        idleSteps(2, "refire");
        applyStimulus(4'b0010, 1'b0, "refire");
        drain("refire");

        $display("[TB] clear interaction");
        resetPulse("reset5");
        applyStimulus(4'b0110, 1'b1, "clr");
        idleSteps(4, "clr");
        applyStimulus(4'b0000, 1'b1, "clr");
        drain("clr");

        $display("[TB] reset during second pulse");
        applyStimulus(4'b0100, 1'b0, "midrst");
        idleSteps(11, "midrst");
        #2;
        rst = 1'b1;
        #1;
        compared++;
        assert (led === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL async_rst led: observed %b expected 0", led);
        end
        compared++;
        assert (busy === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL async_rst busy: observed %b expected 0", busy);
        end
        compared++;
        assert (pending === 4'b0000) else begin
            mismatched++;
            $error("[TB] FAIL async_rst pending: observed %b expected 0000", pending);
        end
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("after_rst");
        idleSteps(30, "after_rst");

        $display("[TB] randomized soak");
        for (int i = 0; i < 600; i++) begin
            logic [3:0] e;
            logic       c;
            e = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            c = ($urandom_range(0, 24) == 0);
            applyStimulus(e, c, "random");
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
